// File: rtl/mos_bus_pkg.sv
// rtl/mos_bus_pkg.sv - shared encodings for the 6502-style memory responder
package mos_bus_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Reset-vector byte addresses; reads are served from RESET_VECTOR, writes are refused
  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_vector(input logic [15:0] addr);
    return (addr == VEC_LO_ADDR) || (addr == VEC_HI_ADDR);
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - single-port byte RAM, synchronous write, registered read
module mem_resp_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem_q [2**ADDR_BITS];
  logic [7:0] rdata_q;

  // Contents are deliberately not reset; read-during-write returns the old byte
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated CPU memory responder; MEM_RESP_WPROT_EN enables ROM write protection
module mem_responder
  import mos_bus_pkg::*;
#(
  parameter int          WAIT_STATES  = 1,
  parameter int          ADDR_BITS    = 10,
  parameter logic [15:0] RESET_VECTOR = 16'h0200,
  parameter logic [15:0] ROM_BASE     = 16'hF000
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        req,
  input  logic        r_w,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        busy,
  output logic        wr_err
);

`ifdef MEM_RESP_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t         state_q, state_d;
  logic [15:0]    addr_q, addr_d;
  logic           r_w_q, r_w_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           wr_err_q, wr_err_d;

  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_we;
  logic [7:0]           ram_rdata;
  logic                 vec_hit;
  logic                 rom_hit;
  logic                 suppress;

  // RAM address follows the bus while idle so a zero-wait read has its data at the RESP edge
  always_comb begin
    vec_hit  = is_vector(addr_q);
    rom_hit  = WPROT_EN && (addr_q >= ROM_BASE);
    suppress = vec_hit || rom_hit;
    ram_addr = (state_q == IDLE) ? address[ADDR_BITS-1:0] : addr_q[ADDR_BITS-1:0];
    ram_we   = (state_q == RESP) && (r_w_q == RW_WRITE) && !suppress && !rst;
  end

  mem_resp_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk_1),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state and registered-output logic for the IDLE/WAIT/RESP access sequence
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    r_w_d    = r_w_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    wr_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = address;
          r_w_d   = r_w;
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (WS == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (r_w_q == RW_READ) begin
          if (addr_q == VEC_LO_ADDR) begin
            rdata_d = RESET_VECTOR[7:0];
          end else if (addr_q == VEC_HI_ADDR) begin
            rdata_d = RESET_VECTOR[15:8];
          end else begin
            rdata_d = ram_rdata;
          end
        end else begin
          wr_err_d = suppress;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 16'h0000;
      r_w_q    <= RW_READ;
      wdata_q  <= 8'h00;
      cnt_q    <= 4'd0;
      rdata_q  <= 8'h00;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      r_w_q    <= r_w_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (WAIT_STATES=1 and 0)
module tb_mem_responder;

`ifdef MEM_RESP_WPROT_EN
  localparam bit EXP_WPROT = 1'b1;
`else
  localparam bit EXP_WPROT = 1'b0;
`endif

  logic        clk_1 = 1'b0;
  logic        rst   = 1'b1;

  logic        req0 = 1'b0, r_w0 = 1'b1;
  logic [15:0] addr0 = 16'h0;
  logic [7:0]  wdata0 = 8'h0;
  logic [7:0]  rdata0;
  logic        ready0, busy0, wr_err0;

  logic        req1 = 1'b0, r_w1 = 1'b1;
  logic [15:0] addr1 = 16'h0;
  logic [7:0]  wdata1 = 8'h0;
  logic [7:0]  rdata1;
  logic        ready1, busy1, wr_err1;

  int checks   = 0;
  int failures = 0;

  always #5 clk_1 = ~clk_1;

  mem_responder #(.WAIT_STATES(1)) dut0 (
    .clk_1(clk_1), .rst(rst), .req(req0), .r_w(r_w0), .address(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .wr_err(wr_err0)
  );

  mem_responder #(.WAIT_STATES(0)) dut1 (
    .clk_1(clk_1), .rst(rst), .req(req1), .r_w(r_w1), .address(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .busy(busy1), .wr_err(wr_err1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit sel, input logic rw, input logic [15:0] a, input logic [7:0] d,
                        output int lat, output logic busy_acc, output logic [7:0] rd, output logic err);
    logic rdy;
    @(negedge clk_1);
    if (sel) begin req1 = 1'b1; r_w1 = rw; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; r_w0 = rw; addr0 = a; wdata0 = d; end
    @(posedge clk_1); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    busy_acc = sel ? busy1 : busy0;
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(posedge clk_1); #1;
      lat++;
      rdy = sel ? ready1 : ready0;
    end
    rd  = sel ? rdata1 : rdata0;
    err = sel ? wr_err1 : wr_err0;
    chk("ready_seen", 16'(rdy), 16'h1);
  endtask

  int         lat;
  logic       bacc;
  logic [7:0] rd;
  logic       err;
  int         pulses;
  logic [7:0] bexp [4];

  initial begin
    bexp[0] = 8'h10; bexp[1] = 8'h21; bexp[2] = 8'h32; bexp[3] = 8'h43;

    repeat (2) @(posedge clk_1);
    @(negedge clk_1); rst = 1'b0;
    chk("rst_rdata", 16'(rdata0), 16'h00);
    chk("rst_ready", 16'(ready0), 16'h0);
    chk("rst_busy", 16'(busy0), 16'h0);
    chk("rst_wr_err", 16'(wr_err0), 16'h0);
    chk("rst_busy1", 16'(busy1), 16'h0);

    // Basic write then read, latency WAIT_STATES+1 = 2
    access(0, 1'b0, 16'h0010, 8'hA5, lat, bacc, rd, err);
    chk("wr_lat", 16'(lat), 16'd2);
    chk("wr_busy_after_accept", 16'(bacc), 16'h1);
    chk("wr_err_normal", 16'(err), 16'h0);
    chk("wr_rdata_unchanged", 16'(rd), 16'h00);
    access(0, 1'b1, 16'h0010, 8'h00, lat, bacc, rd, err);
    chk("rd_lat", 16'(lat), 16'd2);
    chk("rd_0010", 16'(rd), 16'hA5);

    // Reset-vector reads and refused vector write
    access(0, 1'b1, 16'hFFFC, 8'h00, lat, bacc, rd, err);
    chk("rd_fffc", 16'(rd), 16'h00);
    chk("rd_fffc_err", 16'(err), 16'h0);
    access(0, 1'b1, 16'hFFFD, 8'h00, lat, bacc, rd, err);
    chk("rd_fffd", 16'(rd), 16'h02);
    access(0, 1'b0, 16'hFFFC, 8'h77, lat, bacc, rd, err);
    chk("wr_fffc_err", 16'(err), 16'h1);
    chk("wr_fffc_rdata_hold", 16'(rd), 16'h02);
    @(posedge clk_1); #1;
    chk("wr_err_one_cycle", 16'(wr_err0), 16'h0);
    access(0, 1'b1, 16'hFFFC, 8'h00, lat, bacc, rd, err);
    chk("rd_fffc_after_wr", 16'(rd), 16'h00);
    access(0, 1'b1, 16'h03FC, 8'h00, lat, bacc, rd, err);
    chk("rd_alias_3fc_not_written", 16'(rd) == 16'h77 ? 16'h1 : 16'h0, 16'h0);

    // Aliasing through ADDR_BITS=10
    access(0, 1'b0, 16'h0405, 8'h3C, lat, bacc, rd, err);
    access(0, 1'b1, 16'h0005, 8'h00, lat, bacc, rd, err);
    chk("rd_alias_0005", 16'(rd), 16'h3C);
    access(0, 1'b0, 16'h0006, 8'h99, lat, bacc, rd, err);
    chk("wr_keeps_rdata", 16'(rd), 16'h3C);

    // Reset aborts: during WAIT, then at the RESP edge
    access(0, 1'b0, 16'h0020, 8'h5A, lat, bacc, rd, err);
    access(0, 1'b1, 16'h0010, 8'h00, lat, bacc, rd, err);
    chk("rd_before_abort", 16'(rd), 16'hA5);
    @(negedge clk_1); req0 = 1'b1; r_w0 = 1'b0; addr0 = 16'h0020; wdata0 = 8'hFF;
    @(posedge clk_1); #1; req0 = 1'b0;
    @(negedge clk_1); rst = 1'b1;
    @(posedge clk_1); #1;
    chk("abort_wait_busy", 16'(busy0), 16'h0);
    chk("abort_wait_ready", 16'(ready0), 16'h0);
    chk("abort_rdata_reset", 16'(rdata0), 16'h00);
    @(negedge clk_1); rst = 1'b0;
    pulses = 0;
    repeat (3) begin @(posedge clk_1); #1; if (ready0) pulses++; end
    chk("abort_wait_no_ready", 16'(pulses), 16'd0);
    @(negedge clk_1); req0 = 1'b1; r_w0 = 1'b0; addr0 = 16'h0020; wdata0 = 8'hFF;
    @(posedge clk_1); #1; req0 = 1'b0;
    @(posedge clk_1);
    @(negedge clk_1); rst = 1'b1;
    @(posedge clk_1); #1;
    chk("abort_resp_ready", 16'(ready0), 16'h0);
    chk("abort_resp_busy", 16'(busy0), 16'h0);
    @(negedge clk_1); rst = 1'b0;
    pulses = 0;
    repeat (3) begin @(posedge clk_1); #1; if (ready0) pulses++; end
    chk("abort_resp_no_ready", 16'(pulses), 16'd0);
    access(0, 1'b1, 16'h0020, 8'h00, lat, bacc, rd, err);
    chk("abort_ram_unchanged", 16'(rd), 16'h5A);

    // ROM write protection (only refused when MEM_RESP_WPROT_EN is defined)
    access(0, 1'b0, 16'h0000, 8'h66, lat, bacc, rd, err);
    access(0, 1'b0, 16'hF000, 8'h11, lat, bacc, rd, err);
    chk("wr_f000_err", 16'(err), 16'(EXP_WPROT));
    access(0, 1'b1, 16'hF000, 8'h00, lat, bacc, rd, err);
    chk("rd_f000", 16'(rd), EXP_WPROT ? 16'h66 : 16'h11);
    access(0, 1'b0, 16'hEFFF, 8'h42, lat, bacc, rd, err);
    chk("wr_efff_err", 16'(err), 16'h0);
    access(0, 1'b1, 16'hEFFF, 8'h00, lat, bacc, rd, err);
    chk("rd_efff", 16'(rd), 16'h42);

    // Zero-wait-state instance: preload, then back-to-back reads with req held
    access(1, 1'b0, 16'h0001, 8'h10, lat, bacc, rd, err);
    chk("ws0_lat", 16'(lat), 16'd1);
    access(1, 1'b0, 16'h0002, 8'h21, lat, bacc, rd, err);
    access(1, 1'b0, 16'h0003, 8'h32, lat, bacc, rd, err);
    access(1, 1'b0, 16'h0004, 8'h43, lat, bacc, rd, err);
    access(1, 1'b0, 16'h0100, 8'h55, lat, bacc, rd, err);
    @(negedge clk_1); req1 = 1'b1; r_w1 = 1'b1; addr1 = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_1); #1;
      chk("burst_busy", 16'(busy1), 16'h1);
      chk("burst_gap", 16'(ready1), 16'h0);
      req1 = 1'b0; r_w1 = 1'b0; addr1 = 16'h0100; wdata1 = 8'hEE;
      @(negedge clk_1); req1 = 1'b1;
      @(posedge clk_1); #1;
      chk("burst_ready", 16'(ready1), 16'h1);
      chk("burst_rdata", 16'(rdata1), 16'(bexp[k]));
      r_w1 = 1'b1; addr1 = 16'(k + 2);
    end
    req1 = 1'b0;
    repeat (2) @(posedge clk_1); #1;
    chk("burst_rdata_hold", 16'(rdata1), 16'h43);
    chk("burst_idle_busy", 16'(busy1), 16'h0);
    access(1, 1'b1, 16'h0100, 8'h00, lat, bacc, rd, err);
    chk("burst_ignored_write", 16'(rd), 16'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1, SHALL set the extra cycles inserted before the response (legal range 0..15).
REQ-002 Parameter ADDR_BITS, default 10, SHALL set the backing RAM depth to 2^ADDR_BITS bytes.
REQ-003 Parameter RESET_VECTOR, default 16'h0200, SHALL set the 16-bit value served at the reset-vector addresses.
REQ-004 Parameter ROM_BASE, default 16'hF000, SHALL set the lowest write-protected address (used only under REQ-024).
REQ-005 clk_1  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-007 req  in  1  SHALL flag a CPU access request valid.
REQ-008 r_w  in  1  SHALL select direction: 1 = read, 0 = write.
REQ-009 address  in  16  SHALL carry the CPU byte address.
REQ-010 wdata  in  8  SHALL carry the write data.
REQ-011 rdata  out  8  SHALL carry the read data, valid while ready is high.
REQ-012 ready  out  1  SHALL pulse high for exactly one cycle per completed access.
REQ-013 busy  out  1  SHALL be high while an access is in progress.
REQ-014 wr_err  out  1  SHALL pulse with ready when a write was suppressed.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP.
REQ-016 In IDLE with req high, the block SHALL latch address, r_w and wdata, assert busy next cycle, and go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0); req SHALL be ignored outside IDLE.
REQ-017 WAIT SHALL load a counter with WAIT_STATES on entry, decrement every cycle, and go to RESP when the count reaches 1.
REQ-018 On the RESP edge the access SHALL be performed; ready SHALL be high, and busy low, in the cycle after that edge, and the FSM SHALL return to IDLE; latency from the accept edge to ready high SHALL be WAIT_STATES+1 cycles.
REQ-019 Reads SHALL return RAM[address[ADDR_BITS-1:0]] (upper bits alias), except 16'hFFFC -> RESET_VECTOR[7:0] and 16'hFFFD -> RESET_VECTOR[15:8].
REQ-020 Writes SHALL update RAM[address[ADDR_BITS-1:0]]; writes to 16'hFFFC/16'hFFFD SHALL be suppressed with wr_err pulsed.
REQ-021 rdata SHALL hold its last value outside ready cycles; a write SHALL leave rdata unchanged.
REQ-022 req held high across ready SHALL be accepted again in the following IDLE cycle (one access per WAIT_STATES+2 cycles maximum).

Reset
REQ-023 rst SHALL force IDLE, rdata=8'h00, ready=0, busy=0, wr_err=0 and counter=0; RAM contents SHALL NOT be reset; rst high at a RESP edge SHALL abort the access with no RAM write and no ready pulse.

Configuration
REQ-024 With MEM_RESP_WPROT_EN defined, writes with address >= ROM_BASE SHALL be suppressed and wr_err pulsed with ready; without it, only REQ-020 vector suppression SHALL apply.

Structure
REQ-025 Package mos_bus_pkg SHALL hold RW_READ/RW_WRITE encodings, vector addresses 16'hFFFC/16'hFFFD, and the FSM state encoding.
REQ-026 Storage SHALL be sub-module mem_resp_ram: single-port, synchronous write, registered read, depth 2^ADDR_BITS.

Verification
REQ-027 Write 8'hA5 to 16'h0010, then read 16'h0010 -> ready 2 cycles after each accept (WAIT_STATES=1), rdata=8'hA5.
REQ-028 Read 16'hFFFC then 16'hFFFD -> rdata 8'h00 then 8'h02; write to 16'hFFFC -> wr_err pulses, subsequent read still 8'h00.
REQ-029 ADDR_BITS=10, write 8'h3C to 16'h0405, read 16'h0005 -> 8'h3C (aliasing).
REQ-030 rst asserted during WAIT of a write of 8'hFF to 16'h0020 -> no ready pulse, busy=0 next cycle, RAM[16'h0020] unchanged.
REQ-031 MEM_RESP_WPROT_EN defined, write 8'h11 to 16'hF000 -> wr_err=1 with ready, read-back unchanged; 16'hEFFF write succeeds.
REQ-032 WAIT_STATES=0, req held high with four reads -> ready every 2nd cycle, req toggles during busy ignored.
